// File: rtl/exc_int_ctrl_if.sv
// Signal bundle between the exception sequencer, CP0 and the decode/fetch stages.
// The slave modport is the sequencer's view; master is the surrounding pipeline/CP0.
interface exc_int_ctrl_if;
  logic [5:0]  intr;
  logic        intimer;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        id_valid;
  logic        id_syscall;
  logic        id_eret;
  logic [31:0] id_pc;
  logic [31:0] excptype;
  logic [31:0] exc_pc;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport slave (
    input  intr, intimer, status, cause, epc, id_valid, id_syscall, id_eret, id_pc,
    output excptype, exc_pc, stall, flush, redirect_valid, redirect_pc
  );

  modport master (
    output intr, intimer, status, cause, epc, id_valid, id_syscall, id_eret, id_pc,
    input  excptype, exc_pc, stall, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_int_ctrl.sv
// Exception/interrupt sequencer: IDLE -> COMMIT -> FLUSH(xN) -> REDIRECT.
// Optional EXC_IRQ_SYNC_EN adds a 2-flop synchronizer on intr/intimer.
module exc_int_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0040,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  exc_int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_FLUSH, S_REDIRECT} state_e;
  typedef enum logic [1:0] {K_NONE, K_INT, K_SYS, K_ERET} kind_e;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [5:0]  intr_s;
  logic        timer_s;

`ifdef EXC_IRQ_SYNC_EN
  logic [6:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.intimer, bus.intr};
      sync2_q <= sync1_q;
    end
  end
  assign intr_s  = sync2_q[5:0];
  assign timer_s = sync2_q[6];
`else
  assign intr_s  = bus.intr;
  assign timer_s = bus.intimer;
`endif

  // Timer shares IP7 with intr[5].
  logic [7:0] ip;
  logic       int_req, sys_req, eret_req;
  assign ip       = {intr_s[5] | timer_s, intr_s[4:0], bus.cause[9:8]};
  assign int_req  = bus.status[0] & ~bus.status[1] & (|(ip & bus.status[15:8]));
  assign sys_req  = bus.id_valid & bus.id_syscall;
  assign eret_req = bus.id_valid & bus.id_eret;

  logic unused_bits;
  assign unused_bits = ^{bus.status[31:16], bus.status[7:2], bus.cause[31:10], bus.cause[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kind_q  <= K_NONE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (int_req) begin
          kind_d  = K_INT;
          pc_d    = bus.id_valid ? bus.id_pc : 32'h0;
          state_d = S_COMMIT;
        end else if (sys_req) begin
          kind_d  = K_SYS;
          pc_d    = bus.id_pc;
          state_d = S_COMMIT;
        end else if (eret_req) begin
          kind_d  = K_ERET;
          pc_d    = bus.id_pc;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        cnt_d   = 4'(FLUSH_CYCLES);
        state_d = S_FLUSH;
      end
      S_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.excptype       = 32'h0;
    bus.exc_pc         = 32'h0;
    bus.stall          = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    case (state_q)
      S_COMMIT: begin
        bus.stall  = 1'b1;
        bus.exc_pc = pc_q;
        case (kind_q)
          K_INT:   bus.excptype = 32'h0000_0004;
          K_SYS:   bus.excptype = 32'h0000_0100;
          K_ERET:  bus.excptype = 32'h0000_0200;
          default: bus.excptype = 32'h0;
        endcase
      end
      S_FLUSH: begin
        bus.stall = 1'b1;
        bus.flush = 1'b1;
      end
      S_REDIRECT: begin
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        // CP0 already holds the updated EPC by the time eret redirects.
        bus.redirect_pc    = (kind_q == K_ERET) ? bus.epc : HANDLER_ADDR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exc_int_ctrl.sv
// Directed bench for exc_int_ctrl (default build, no input synchronizer).
module tb_exc_int_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  exc_int_ctrl_if ifc ();

  exc_int_ctrl #(.HANDLER_ADDR(32'h0000_0040), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] exc, input logic [31:0] epc_o,
                          input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
    check({tag, ".excptype"}, ifc.excptype, exc);
    check({tag, ".exc_pc"}, ifc.exc_pc, epc_o);
    check({tag, ".stall"}, {31'h0, ifc.stall}, {31'h0, st});
    check({tag, ".flush"}, {31'h0, ifc.flush}, {31'h0, fl});
    check({tag, ".redirect_valid"}, {31'h0, ifc.redirect_valid}, {31'h0, rv});
    check({tag, ".redirect_pc"}, ifc.redirect_pc, rpc);
  endtask

  task automatic clear_id();
    ifc.id_valid   = 1'b0;
    ifc.id_syscall = 1'b0;
    ifc.id_eret    = 1'b0;
    ifc.id_pc      = 32'h0;
  endtask

  // Inputs were applied before edge N; walk cycles N+1..N+5 and check the full sequence.
  task automatic run_seq(input string tag, input logic [31:0] exc, input logic [31:0] epc_o,
                         input logic [31:0] rpc);
    @(negedge clk);
    clear_id();
    ifc.intr    = 6'h0;
    ifc.intimer = 1'b0;
    chk_outs({tag, ".commit"}, exc, epc_o, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk_outs({tag, ".flush1"}, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk_outs({tag, ".flush2"}, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk_outs({tag, ".redirect"}, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, rpc);
    @(negedge clk);
    chk_outs({tag, ".idle"}, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst         = 1'b1;
    ifc.intr    = 6'h0;
    ifc.intimer = 1'b0;
    ifc.status  = 32'h0;
    ifc.cause   = 32'h0;
    ifc.epc     = 32'h0;
    clear_id();
    repeat (2) @(negedge clk);
    chk_outs("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    // Hardware interrupt on IP2 with IM2 set, no valid instruction -> pc 0.
    @(negedge clk);
    ifc.status = 32'h0000_0401;
    ifc.intr   = 6'b000001;
    run_seq("hw_int", 32'h4, 32'h0, 32'h40);

    // Syscall with interrupts disabled.
    ifc.status     = 32'h0;
    ifc.id_valid   = 1'b1;
    ifc.id_syscall = 1'b1;
    ifc.id_pc      = 32'h1000;
    run_seq("syscall", 32'h100, 32'h1000, 32'h40);

    // Eret redirects to EPC.
    ifc.epc      = 32'h1004;
    ifc.id_valid = 1'b1;
    ifc.id_eret  = 1'b1;
    ifc.id_pc    = 32'h1008;
    run_seq("eret", 32'h200, 32'h1008, 32'h1004);

    // Syscall and eret together: syscall wins.
    ifc.id_valid   = 1'b1;
    ifc.id_syscall = 1'b1;
    ifc.id_eret    = 1'b1;
    ifc.id_pc      = 32'h3000;
    run_seq("sys_eret", 32'h100, 32'h3000, 32'h40);

    // Timer interrupt through IP7.
    ifc.status  = 32'h0000_8001;
    ifc.intimer = 1'b1;
    run_seq("timer", 32'h4, 32'h0, 32'h40);

    // Software interrupt cause[9] through IM1, with a non-syscall valid instruction.
    ifc.status   = 32'h0000_0201;
    ifc.cause    = 32'h0000_0200;
    ifc.id_valid = 1'b1;
    ifc.id_pc    = 32'h5000;
    run_seq("sw_int", 32'h4, 32'h5000, 32'h40);
    ifc.cause = 32'h0;

    // Masked: EXL set, then IM bit clear; nothing must start.
    ifc.status = 32'h0000_0403;
    ifc.intr   = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_outs("mask_exl", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    ifc.status = 32'h0000_0801;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_outs("mask_im", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    ifc.status = 32'h0000_0400;
    @(negedge clk);
    chk_outs("mask_ie", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ifc.intr = 6'h0;

    // Interrupt + syscall together; repeat syscall during FLUSH is dropped.
    ifc.status     = 32'h0000_0401;
    ifc.intr       = 6'b000001;
    ifc.id_valid   = 1'b1;
    ifc.id_syscall = 1'b1;
    ifc.id_pc      = 32'h2000;
    @(negedge clk);
    ifc.intr = 6'h0;
    clear_id();
    chk_outs("int_sys.commit", 32'h4, 32'h2000, 1'b1, 1'b0, 1'b0, 32'h0);
    ifc.id_valid   = 1'b1;
    ifc.id_syscall = 1'b1;
    ifc.id_pc      = 32'h2004;
    @(negedge clk);
    chk_outs("int_sys.flush1", 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    clear_id();
    @(negedge clk);
    chk_outs("int_sys.flush2", 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk_outs("int_sys.redirect", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h40);
    @(negedge clk);
    chk_outs("int_sys.idle", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk_outs("int_sys.noreplay", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset held 3 cycles mid-FLUSH: no redirect, back to idle.
    ifc.status     = 32'h0;
    ifc.id_valid   = 1'b1;
    ifc.id_syscall = 1'b1;
    ifc.id_pc      = 32'h1000;
    @(negedge clk);
    clear_id();
    @(negedge clk);
    chk_outs("rst_mid.flush1", 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_outs("rst_mid.hold", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_outs("rst_mid.after", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
